// File: rtl/fb_mcram.sv
// Framebuffer RAM: N round-robin write channels plus a clear-screen fill engine
// sharing one BRAM write port, with a 1- or 2-cycle pipelined read port.
module fb_mcram #(
   parameter int DEPTH  = 320*240,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 12,
   parameter int N_WR   = 4,
   parameter int RD_LAT = 2
) (
   input  logic                     clk100,
   input  logic                     rst_n,
   input  logic [N_WR-1:0]          wr_valid,
   output logic [N_WR-1:0]          wr_ready,
   input  logic [N_WR*ADDR_W-1:0]   wr_addr,
   input  logic [N_WR*DATA_W-1:0]   wr_data,
   input  logic                     fill_start,
   input  logic [DATA_W-1:0]        fill_color,
   output logic                     fill_busy,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     rd_valid,
   output logic                     oob_err
);

   localparam int PTR_W = (N_WR > 1) ? $clog2(N_WR) : 1;

   typedef enum logic [0:0] {IDLE, FILL} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   fill_addr;
   logic [DATA_W-1:0]   fill_color_q;
   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    gnt_idx;
   logic                gnt_any;
   logic [N_WR-1:0]     gnt;
   logic [ADDR_W-1:0]   wa_sel;
   logic [DATA_W-1:0]   wd_sel;
   logic                wr_oob;
   logic                rd_oob;
   logic                mem_we;
   logic [ADDR_W-1:0]   mem_wa;
   logic [DATA_W-1:0]   mem_wd;

   logic [DATA_W-1:0]   mem [0:DEPTH-1];
   logic [DATA_W-1:0]   ram_q_p0;
   logic                vld_p0;
   logic                oob_p0;

   // Arbitration: first requester at or after rr_ptr, wrapping; no grants while filling
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < N_WR; k++) begin
         if (!gnt_any && wr_valid[(int'(rr_ptr) + k) % N_WR]) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'((int'(rr_ptr) + k) % N_WR);
         end
      end
      if (state != IDLE || !rst_n) begin
         gnt_any = 1'b0;
      end
      gnt = gnt_any ? (N_WR'(1) << gnt_idx) : '0;
   end

   assign wr_ready  = gnt;
   assign fill_busy = (state == FILL);
   assign wa_sel    = wr_addr[gnt_idx*ADDR_W +: ADDR_W];
   assign wd_sel    = wr_data[gnt_idx*DATA_W +: DATA_W];
   assign wr_oob    = gnt_any && (32'(wa_sel) >= DEPTH);
   assign rd_oob    = rd_en && (32'(rd_addr) >= DEPTH);

   always_comb begin
      mem_we = 1'b0;
      mem_wa = wa_sel;
      mem_wd = wd_sel;
      if (state == FILL) begin
         mem_we = 1'b1;
         mem_wa = fill_addr;
         mem_wd = fill_color_q;
      end else if (gnt_any && !wr_oob) begin
         mem_we = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (fill_start) state_nxt = FILL;
         FILL:    if (fill_addr == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         fill_addr <= '0;
         rr_ptr    <= '0;
         oob_err   <= 1'b0;
      end else begin
         if (state == IDLE && fill_start) begin
            fill_addr <= '0;
         end else if (state == FILL) begin
            fill_addr <= fill_addr + 1'b1;
         end
         if (gnt_any) begin
            rr_ptr <= (gnt_idx == PTR_W'(N_WR-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (wr_oob || rd_oob) begin
            oob_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk100) begin
      if (state == IDLE && fill_start) begin
         fill_color_q <= fill_color;
      end
   end

   // Stage p0: BRAM array access, read-first on same-address collision
   always_ff @(posedge clk100) begin
      if (mem_we) begin
         mem[mem_wa] <= mem_wd;
      end
      if (rd_en) begin
         ram_q_p0 <= mem[rd_addr];
      end
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         oob_p0 <= 1'b0;
      end else begin
         vld_p0 <= rd_en;
         oob_p0 <= rd_oob;
      end
   end

   // Stage p1: optional output register after the BRAM
   generate
      if (RD_LAT == 2) begin : g_lat2
         logic [DATA_W-1:0] rd_data_p1;
         logic              vld_p1;
         always_ff @(posedge clk100 or negedge rst_n) begin
            if (!rst_n) begin
               vld_p1     <= 1'b0;
               rd_data_p1 <= '0;
            end else begin
               vld_p1 <= vld_p0;
               if (vld_p0) begin
                  rd_data_p1 <= oob_p0 ? '0 : ram_q_p0;
               end
            end
         end
         assign rd_data  = rd_data_p1;
         assign rd_valid = vld_p1;
      end else begin : g_lat1
         assign rd_data  = (vld_p0 && !oob_p0) ? ram_q_p0 : '0;
         assign rd_valid = vld_p0;
      end
   endgenerate

endmodule

// File: tb/tb_fb_mcram.sv
// Directed bench for fb_mcram: round-robin, fill, collision, out-of-range and reset-mid-fill.
`timescale 1ns/1ps
module tb_fb_mcram;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 7;
   localparam int DATA_W = 12;
   localparam int N_WR   = 4;
   localparam int RD_LAT = 2;

   logic                   clk100;
   logic                   rst_n;
   logic [N_WR-1:0]        wr_valid;
   logic [N_WR-1:0]        wr_ready;
   logic [N_WR*ADDR_W-1:0] wr_addr;
   logic [N_WR*DATA_W-1:0] wr_data;
   logic                   fill_start;
   logic [DATA_W-1:0]      fill_color;
   logic                   fill_busy;
   logic                   rd_en;
   logic [ADDR_W-1:0]      rd_addr;
   logic [DATA_W-1:0]      rd_data;
   logic                   rd_valid;
   logic                   oob_err;

   int nchecks = 0;
   int nerr    = 0;

   fb_mcram #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_WR(N_WR), .RD_LAT(RD_LAT)
   ) dut (
      .clk100(clk100), .rst_n(rst_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .fill_start(fill_start), .fill_color(fill_color), .fill_busy(fill_busy),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .oob_err(oob_err)
   );

   initial begin
      clk100 = 1'b0;
      forever #5 clk100 = ~clk100;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk100);
      #1;
   endtask

   task automatic set_ch(input int ch, input int a, input logic [DATA_W-1:0] d);
      wr_addr[ch*ADDR_W +: ADDR_W] = ADDR_W'(a);
      wr_data[ch*DATA_W +: DATA_W] = d;
   endtask

   task automatic rd_chk(input string tag, input int a, input logic [DATA_W-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(a);
      step();
      rd_en = 1'b0;
      step();
      chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
      chk(tag, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      rst_n      = 1'b0;
      wr_valid   = '1;
      wr_addr    = '0;
      wr_data    = '0;
      fill_start = 1'b0;
      fill_color = '0;
      rd_en      = 1'b0;
      rd_addr    = '0;
      #2;
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_fill_busy", 32'(fill_busy), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_oob_err", 32'(oob_err), 32'd0);
      step();
      step();

      // Round-robin: all channels requesting, grants 0,1,2,3,0,...
      for (int i = 0; i < N_WR; i++) set_ch(i, i, DATA_W'(12'h700 + i));
      rst_n = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         chk("rr_grant", 32'(wr_ready), 32'(4'b0001 << (c % 4)));
         step();
         set_ch(c % 4, c + 4, DATA_W'(12'h700 + c + 4));
         #1;
      end
      wr_valid = '0;
      for (int a = 0; a < 8; a++) rd_chk("rr_readback", a, DATA_W'(12'h700 + a));

      // Read/write collision on address 10
      wr_valid = 4'b0001;
      set_ch(0, 10, 12'h111);
      step();
      wr_valid = 4'b0000;
      step();
      wr_valid = 4'b0010;
      set_ch(1, 10, 12'h222);
      rd_en   = 1'b1;
      rd_addr = 7'd10;
      #1;
      chk("coll_grant", 32'(wr_ready), 32'b0010);
      step();
      wr_valid = 4'b0000;
      chk("coll_vld_gap", 32'(rd_valid), 32'd0);
      step();
      rd_en = 1'b0;
      chk("coll_vld_old", 32'(rd_valid), 32'd1);
      chk("coll_old_data", 32'(rd_data), 32'h111);
      step();
      chk("coll_vld_new", 32'(rd_valid), 32'd1);
      chk("coll_new_data", 32'(rd_data), 32'h222);
      step();
      chk("coll_vld_end", 32'(rd_valid), 32'd0);

      // Out-of-range write and read
      chk("oob_clear", 32'(oob_err), 32'd0);
      wr_valid = 4'b1000;
      set_ch(3, DEPTH + 1, 12'hFFF);
      #1;
      chk("oob_grant", 32'(wr_ready), 32'b1000);
      step();
      wr_valid = 4'b0000;
      chk("oob_set", 32'(oob_err), 32'd1);
      rd_chk("oob_alias_addr1", 1, 12'h701);
      rd_chk("oob_addr10", 10, 12'h222);
      rd_chk("oob_read", DEPTH, 12'h000);
      chk("oob_sticky", 32'(oob_err), 32'd1);

      // Fill with a simultaneous channel-2 write
      fill_start = 1'b1;
      fill_color = 12'h0F0;
      wr_valid   = 4'b0100;
      set_ch(2, 5, 12'hABC);
      #1;
      chk("fill_sim_grant", 32'(wr_ready), 32'b0100);
      chk("fill_sim_busy0", 32'(fill_busy), 32'd0);
      step();
      fill_start = 1'b0;
      fill_color = 12'h000;
      wr_valid   = 4'b0001;
      set_ch(0, DEPTH + 1, 12'h555);
      #1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("fill_busy", 32'(fill_busy), 32'd1);
         chk("fill_no_grant", 32'(wr_ready), 32'd0);
         step();
      end
      chk("fill_done", 32'(fill_busy), 32'd0);
      chk("fill_resume_grant", 32'(wr_ready), 32'b0001);
      step();
      wr_valid = 4'b0000;
      for (int a = 0; a < DEPTH; a++) rd_chk("fill_readback", a, 12'h0F0);

      // Reset asserted partway through a second fill
      fill_start = 1'b1;
      fill_color = 12'h00F;
      step();
      fill_start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      chk("midfill_busy", 32'(fill_busy), 32'd1);
      rst_n    = 1'b0;
      wr_valid = 4'b1111;
      #1;
      chk("midrst_fill_busy", 32'(fill_busy), 32'd0);
      chk("midrst_wr_ready", 32'(wr_ready), 32'd0);
      chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
      chk("midrst_rd_data", 32'(rd_data), 32'd0);
      chk("midrst_oob_err", 32'(oob_err), 32'd0);
      step();
      step();
      wr_valid = 4'b0000;
      rst_n    = 1'b1;
      step();
      chk("postrst_busy", 32'(fill_busy), 32'd0);
      for (int a = 0; a < DEPTH; a++)
         rd_chk("midfill_readback", a, (a < 20) ? 12'h00F : 12'h0F0);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
